bsi_arb: RTL and testbench

Shared shift unit that arbitrates N requesters onto one barrel-shift datapath and returns tagged results through a single registered response port. Each requester issues {op, operand, shift amount} over a valid/ready handshake. A round-robin arbiter grants one request per cycle, and the selected shift result is registered with the requester's ID. The block sits between issue logic in multiple lanes and the common `bsi` shifter datapath.

---
 rtl/bsi_arb_pkg.sv | 13 +
 rtl/bsi_arb_if.sv | 30 +++
 rtl/bsi.sv | 25 ++
 rtl/bsi_arb_rr_pick.sv | 31 +++
 rtl/bsi_arb.sv | 87 ++++++++
 tb/tb_bsi_arb.sv | 382 ++++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/bsi_arb_pkg.sv
// rtl/bsi_arb_pkg.sv - shared op encoding for the bsi arbiter
package bsi_arb_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROL = 2'b11
    } op_t;

endpackage

// File: rtl/bsi_arb_if.sv
// rtl/bsi_arb_if.sv - request/response bundle between issue lanes and the bsi arbiter
interface bsi_arb_if
    import bsi_arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int W       = 32,
    parameter int SHIFT_W = $clog2(W),
    parameter int ID_W    = $clog2(N)
);
    logic [N-1:0]         req_vld_i;
    logic [N*OP_W-1:0]    req_op_i;
    logic [N*W-1:0]       req_x_i;
    logic [N*SHIFT_W-1:0] req_shift_i;
    logic [N-1:0]         req_rdy_o;
    logic                 rsp_vld_o;
    logic                 rsp_rdy_i;
    logic [ID_W-1:0]      rsp_id_o;
    logic [W-1:0]         rsp_y_o;

    modport slave (
        input  req_vld_i, req_op_i, req_x_i, req_shift_i, rsp_rdy_i,
        output req_rdy_o, rsp_vld_o, rsp_id_o, rsp_y_o
    );

    modport master (
        output req_vld_i, req_op_i, req_x_i, req_shift_i, rsp_rdy_i,
        input  req_rdy_o, rsp_vld_o, rsp_id_o, rsp_y_o
    );

endinterface

// File: rtl/bsi.sv
// rtl/bsi.sv - single-function barrel shifter, flavour fixed by parameters
module bsi #(
    parameter int W        = 32,
    parameter int SHIFT_W  = $clog2(W),
    parameter bit P_LEFT   = 1'b0,
    parameter bit P_ARITH  = 1'b0,
    parameter bit P_ROTATE = 1'b0
) (
    input  logic [W-1:0]       x,
    input  logic [SHIFT_W-1:0] shift,
    output logic [W-1:0]       y
);

    if (P_ROTATE) begin : g_rol
        // x >> W is zero, so a zero shift collapses to x without a special case
        assign y = (x << shift) | (x >> (W - int'(shift)));
    end else if (P_LEFT) begin : g_sll
        assign y = x << shift;
    end else if (P_ARITH) begin : g_sra
        assign y = $unsigned($signed(x) >>> shift);
    end else begin : g_srl
        assign y = x >> shift;
    end

endmodule

// File: rtl/bsi_arb_rr_pick.sv
// rtl/bsi_arb_rr_pick.sv - combinational round-robin pick starting at ptr
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_idx,
    output logic            any
);

    int idx;

    // Walk the search order backwards so the candidate nearest ptr lands last
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                gnt_idx = ID_W'(idx);
                any     = 1'b1;
            end
        end
        gnt          = '0;
        gnt[gnt_idx] = any;
    end

endmodule

// File: rtl/bsi_arb.sv
// rtl/bsi_arb.sv - round-robin arbiter of N lanes onto one shared shifter with registered tagged response
module bsi_arb
    import bsi_arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int W       = 32,
    parameter int SHIFT_W = $clog2(W),
    parameter int ID_W    = $clog2(N)
) (
    input logic     clk,
    input logic     arst_n,
    bsi_arb_if.slave bus
);

    logic [ID_W-1:0]    ptr;
    logic [N-1:0]       gnt;
    logic [ID_W-1:0]    g;
    logic               any;
    logic               can_accept;
    logic               accept;
    logic [W-1:0]       sel_x;
    logic [SHIFT_W-1:0] sel_shift;
    op_t                sel_op;
    logic [W-1:0]       y_sll, y_srl, y_sra, y_rol, y_sel;
    logic               rsp_vld;
    logic [ID_W-1:0]    rsp_id;
    logic [W-1:0]       rsp_y;

    rr_pick #(.N(N), .ID_W(ID_W)) u_pick (
        .req     (bus.req_vld_i),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (g),
        .any     (any)
    );

    assign can_accept    = !rsp_vld || bus.rsp_rdy_i;
    assign accept        = can_accept && any;
    assign bus.req_rdy_o = can_accept ? gnt : '0;

    // Only the granted lane reaches the shifters
    assign sel_x     = bus.req_x_i[int'(g)*W +: W];
    assign sel_shift = bus.req_shift_i[int'(g)*SHIFT_W +: SHIFT_W];
    assign sel_op    = op_t'(bus.req_op_i[int'(g)*OP_W +: OP_W]);

    bsi #(.W(W), .SHIFT_W(SHIFT_W), .P_LEFT(1'b1)) u_sll (
        .x(sel_x), .shift(sel_shift), .y(y_sll));
    bsi #(.W(W), .SHIFT_W(SHIFT_W)) u_srl (
        .x(sel_x), .shift(sel_shift), .y(y_srl));
    bsi #(.W(W), .SHIFT_W(SHIFT_W), .P_ARITH(1'b1)) u_sra (
        .x(sel_x), .shift(sel_shift), .y(y_sra));
    bsi #(.W(W), .SHIFT_W(SHIFT_W), .P_ROTATE(1'b1)) u_rol (
        .x(sel_x), .shift(sel_shift), .y(y_rol));

    always_comb begin
        y_sel = y_sll;
        case (sel_op)
            OP_SLL:  y_sel = y_sll;
            OP_SRL:  y_sel = y_srl;
            OP_SRA:  y_sel = y_sra;
            OP_ROL:  y_sel = y_rol;
            default: y_sel = y_sll;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rsp_vld <= 1'b0;
            rsp_id  <= '0;
            rsp_y   <= '0;
            ptr     <= '0;
        end else if (accept) begin
            rsp_vld <= 1'b1;
            rsp_id  <= g;
            rsp_y   <= y_sel;
            // Explicit wrap keeps non-power-of-two N inside 0..N-1
            ptr     <= (int'(g) == N - 1) ? '0 : g + ID_W'(1);
        end else if (rsp_vld && bus.rsp_rdy_i) begin
            rsp_vld <= 1'b0;
        end
    end

    assign bus.rsp_vld_o = rsp_vld;
    assign bus.rsp_id_o  = rsp_id;
    assign bus.rsp_y_o   = rsp_y;

endmodule

// File: tb/tb_bsi_arb.sv
// tb/tb_bsi_arb.sv - randomized self-checking bench for bsi_arb against a behavioural model
module tb_bsi_arb;

    localparam int N       = 4;
    localparam int W       = 32;
    localparam int SHIFT_W = 5;
    localparam int ID_W    = 2;

    logic clk;
    logic arst_n;

    bsi_arb_if #(.N(N), .W(W), .SHIFT_W(SHIFT_W), .ID_W(ID_W)) bus ();

    bsi_arb #(.N(N), .W(W), .SHIFT_W(SHIFT_W), .ID_W(ID_W)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    logic [N-1:0]       r_vld;
    logic [1:0]         r_op [N];
    logic [W-1:0]       r_x  [N];
    logic [SHIFT_W-1:0] r_sh [N];
    logic               rdy;

    int          m_ptr;
    bit          m_vld;
    int          m_id;
    logic [W-1:0] m_y;
    int          last_acc;

    function automatic logic [W-1:0] ref_shift(input logic [1:0] op, input logic [W-1:0] x, input int s);
        case (op)
            2'd0:    return x << s;
            2'd1:    return x >> s;
            2'd2:    return x[W-1] ? ~((~x) >> s) : (x >> s);
            default: return (s == 0) ? x : ((x << s) | (x >> (W - s)));
        endcase
    endfunction

    function automatic int exp_grant(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_rdy_vec(input logic [N-1:0] v, input int p, input bit busy, input logic r);
        int gg;
        gg = exp_grant(v, p);
        if ((!busy || r) && gg >= 0) return N'(1) << gg;
        return '0;
    endfunction

    task automatic apply();
        bus.req_vld_i = r_vld;
        for (int i = 0; i < N; i++) begin
            bus.req_op_i[2*i +: 2]             = r_op[i];
            bus.req_x_i[W*i +: W]              = r_x[i];
            bus.req_shift_i[SHIFT_W*i +: SHIFT_W] = r_sh[i];
        end
        bus.rsp_rdy_i = rdy;
        #1;
    endtask

    // Advances one clock and moves the model by the same rules the block must obey
    task automatic tick();
        int  gg;
        bit  ca;
        ca = !m_vld || rdy;
        gg = exp_grant(r_vld, m_ptr);
        last_acc = -1;
        @(posedge clk);
        if (ca && gg >= 0) begin
            m_vld    = 1'b1;
            m_id     = gg;
            m_y      = ref_shift(r_op[gg], r_x[gg], int'(r_sh[gg]));
            m_ptr    = (gg + 1) % N;
            last_acc = gg;
        end else if (m_vld && rdy) begin
            m_vld = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        r_vld  = '0;
        rdy    = 1'b1;
        for (int i = 0; i < N; i++) begin
            r_op[i] = '0; r_x[i] = '0; r_sh[i] = '0;
        end
        apply();
        m_ptr = 0; m_vld = 1'b0; m_id = 0; m_y = '0;
        #10;
        compared++;
        if (bus.rsp_vld_o !== 1'b0) begin
            mismatched++; $display("FAIL reset_vld: got %b want 0", bus.rsp_vld_o);
        end
        compared++;
        if (bus.rsp_id_o !== '0 || bus.rsp_y_o !== '0) begin
            mismatched++; $display("FAIL reset_data: got id=%0d y=%h want 0/0", bus.rsp_id_o, bus.rsp_y_o);
        end
        compared++;
        if (bus.req_rdy_o !== '0) begin
            mismatched++; $display("FAIL reset_rdy: got %b want 0000", bus.req_rdy_o);
        end
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        r_vld   = 4'b0010;
        r_op[1] = 2'b10;
        r_x[1]  = 32'h8000_0010;
        r_sh[1] = 5'd4;
        rdy     = 1'b1;
        apply();
        compared++;
        if (bus.req_rdy_o !== 4'b0010) begin
            mismatched++; $display("FAIL single_rdy: got %b want 0010", bus.req_rdy_o);
        end
        tick();
        r_vld = '0;
        apply();
        compared++;
        if (bus.rsp_vld_o !== 1'b1 || bus.rsp_id_o !== 2'd1 || bus.rsp_y_o !== 32'hF800_0001) begin
            mismatched++;
            $display("FAIL single_sra: got vld=%b id=%0d y=%h want 1/1/f8000001",
                     bus.rsp_vld_o, bus.rsp_id_o, bus.rsp_y_o);
        end
        tick();
        compared++;
        if (bus.rsp_vld_o !== 1'b0) begin
            mismatched++; $display("FAIL single_drain: got vld=%b want 0", bus.rsp_vld_o);
        end
    endtask

    task automatic test_rol_boundary();
        logic [1:0]  t_op [3] = '{2'b11, 2'b11, 2'b00};
        logic [31:0] t_x  [3] = '{32'h8000_0001, 32'h5A5A_1234, 32'h0000_0001};
        logic [4:0]  t_sh [3] = '{5'd1, 5'd0, 5'd31};
        logic [31:0] t_y  [3] = '{32'h0000_0003, 32'h5A5A_1234, 32'h8000_0000};
        rdy = 1'b1;
        for (int t = 0; t < 3; t++) begin
            r_vld   = 4'b0001;
            r_op[0] = t_op[t];
            r_x[0]  = t_x[t];
            r_sh[0] = t_sh[t];
            apply();
            tick();
            compared++;
            if (bus.rsp_vld_o !== 1'b1 || bus.rsp_id_o !== 2'd0 || bus.rsp_y_o !== t_y[t]) begin
                mismatched++;
                $display("FAIL boundary_%0d: got vld=%b id=%0d y=%h want 1/0/%h",
                         t, bus.rsp_vld_o, bus.rsp_id_o, bus.rsp_y_o, t_y[t]);
            end
        end
        r_vld = '0;
        apply();
        tick();
    endtask

    task automatic test_round_robin();
        int start;
        int id;
        for (int i = 0; i < N; i++) begin
            r_op[i] = 2'(i);
            r_x[i]  = {4'(i), 28'($urandom)} | 32'h8000_0000;
            r_sh[i] = 5'($urandom_range(1, 31));
        end
        r_vld = '1;
        rdy   = 1'b1;
        apply();
        start = m_ptr;
        for (int k = 0; k < 2 * N; k++) begin
            tick();
            id = (start + k) % N;
            compared++;
            if (bus.rsp_vld_o !== 1'b1 || bus.rsp_id_o !== 2'(id) ||
                bus.rsp_y_o !== ref_shift(r_op[id], r_x[id], int'(r_sh[id]))) begin
                mismatched++;
                $display("FAIL rr_cycle_%0d: got vld=%b id=%0d y=%h want 1/%0d/%h", k,
                         bus.rsp_vld_o, bus.rsp_id_o, bus.rsp_y_o, id,
                         ref_shift(r_op[id], r_x[id], int'(r_sh[id])));
            end
        end
        r_vld = '0;
        apply();
        tick();
    endtask

    task automatic test_backpressure();
        logic [ID_W-1:0] sid;
        logic [W-1:0]    sy;
        int              sptr;
        r_vld = '1;
        rdy   = 1'b1;
        apply();
        tick();
        rdy = 1'b0;
        apply();
        sid  = bus.rsp_id_o;
        sy   = bus.rsp_y_o;
        sptr = m_ptr;
        for (int c = 0; c < 5; c++) begin
            compared++;
            if (bus.req_rdy_o !== '0) begin
                mismatched++; $display("FAIL bp_rdy_%0d: got %b want 0000", c, bus.req_rdy_o);
            end
            tick();
            compared++;
            if (bus.rsp_vld_o !== 1'b1 || bus.rsp_id_o !== sid || bus.rsp_y_o !== sy) begin
                mismatched++;
                $display("FAIL bp_hold_%0d: got vld=%b id=%0d y=%h want 1/%0d/%h",
                         c, bus.rsp_vld_o, bus.rsp_id_o, bus.rsp_y_o, sid, sy);
            end
        end
        rdy = 1'b1;
        apply();
        compared++;
        if (bus.req_rdy_o !== (N'(1) << sptr)) begin
            mismatched++; $display("FAIL bp_release_rdy: got %b want %b", bus.req_rdy_o, N'(1) << sptr);
        end
        tick();
        compared++;
        if (bus.rsp_vld_o !== 1'b1 || bus.rsp_id_o !== 2'(sptr)) begin
            mismatched++;
            $display("FAIL bp_release_rsp: got vld=%b id=%0d want 1/%0d", bus.rsp_vld_o, bus.rsp_id_o, sptr);
        end
        r_vld = '0;
        apply();
        tick();
    endtask

    task automatic test_withdraw();
        r_vld = 4'b0001;
        rdy   = 1'b1;
        apply();
        tick();
        rdy   = 1'b0;
        r_vld = 4'b0101;
        apply();
        compared++;
        if (bus.req_rdy_o !== '0) begin
            mismatched++; $display("FAIL withdraw_rdy: got %b want 0000", bus.req_rdy_o);
        end
        tick();
        r_vld = 4'b0001;
        rdy   = 1'b1;
        apply();
        for (int c = 0; c < 6; c++) begin
            tick();
            compared++;
            if (bus.rsp_vld_o !== 1'b1 || bus.rsp_id_o !== 2'd0) begin
                mismatched++;
                $display("FAIL withdraw_rsp_%0d: got vld=%b id=%0d want 1/0", c, bus.rsp_vld_o, bus.rsp_id_o);
            end
        end
        r_vld = '0;
        apply();
        tick();
    endtask

    task automatic test_async_reset();
        r_vld = '1;
        rdy   = 1'b1;
        apply();
        tick();
        rdy = 1'b0;
        apply();
        tick();
        r_vld = '0;
        apply();
        #2;
        arst_n = 1'b0;
        #1;
        m_ptr = 0; m_vld = 1'b0; m_id = 0; m_y = '0;
        compared++;
        if (bus.rsp_vld_o !== 1'b0 || bus.rsp_id_o !== '0 || bus.rsp_y_o !== '0) begin
            mismatched++;
            $display("FAIL arst_clear: got vld=%b id=%0d y=%h want 0/0/0", bus.rsp_vld_o, bus.rsp_id_o, bus.rsp_y_o);
        end
        compared++;
        if (bus.req_rdy_o !== '0) begin
            mismatched++; $display("FAIL arst_rdy: got %b want 0000", bus.req_rdy_o);
        end
        @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        r_vld  = 4'b1100;
        rdy    = 1'b1;
        apply();
        compared++;
        if (bus.req_rdy_o !== 4'b0100) begin
            mismatched++; $display("FAIL arst_first_rdy: got %b want 0100", bus.req_rdy_o);
        end
        tick();
        compared++;
        if (bus.rsp_vld_o !== 1'b1 || bus.rsp_id_o !== 2'd2) begin
            mismatched++; $display("FAIL arst_first_rsp: got vld=%b id=%0d want 1/2", bus.rsp_vld_o, bus.rsp_id_o);
        end
        r_vld = '0;
        apply();
        tick();
    endtask

    task automatic test_random();
        int              wait_cnt [N];
        logic [N-1:0]    exp;
        logic [N-1:0]    acc_dut;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!r_vld[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        r_vld[i] = 1'b1;
                        r_op[i]  = 2'($urandom);
                        r_x[i]   = $urandom;
                        r_sh[i]  = 5'($urandom);
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    r_vld[i]    = 1'b0;
                    wait_cnt[i] = 0;
                end
            end
            rdy = ($urandom_range(0, 3) != 0);
            apply();
            exp = exp_rdy_vec(r_vld, m_ptr, m_vld, rdy);
            compared++;
            if (bus.req_rdy_o !== exp) begin
                mismatched++; $display("FAIL rand_rdy_%0d: got %b want %b", c, bus.req_rdy_o, exp);
            end
            acc_dut = r_vld & bus.req_rdy_o;
            tick();
            for (int i = 0; i < N; i++) begin
                if (acc_dut[i]) begin
                    compared++;
                    if (wait_cnt[i] > N - 1) begin
                        mismatched++; $display("FAIL rand_fair_%0d: req %0d waited %0d accepts want <=%0d", c, i, wait_cnt[i], N - 1);
                    end
                    wait_cnt[i] = 0;
                end else if (r_vld[i] && acc_dut != '0) begin
                    wait_cnt[i]++;
                end
            end
            if (last_acc >= 0) r_vld[last_acc] = 1'b0;
            compared++;
            if (bus.rsp_vld_o !== m_vld || (m_vld && (bus.rsp_id_o !== 2'(m_id) || bus.rsp_y_o !== m_y))) begin
                mismatched++;
                $display("FAIL rand_rsp_%0d: got vld=%b id=%0d y=%h want %b/%0d/%h",
                         c, bus.rsp_vld_o, bus.rsp_id_o, bus.rsp_y_o, m_vld, m_id, m_y);
            end
        end
        r_vld = '0;
        rdy   = 1'b1;
        apply();
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_rol_boundary();
        test_round_robin();
        test_backpressure();
        test_withdraw();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
